traffic_light_ctrl: RTL and testbench

- Moore state machine that sequences the main-street lights, side-street lights and pedestrian walk lamp of one intersection.
- Consumes the already-synchronised sensor, walk-request and reprogram signals produced by the input synchroniser stage.
- A single down-counter times every phase; sensor activity extends side green once per cycle of the sequence.
- Walk requests insert an all-red walk phase; reprogram parks the intersection in all-red.

---
 rtl/traffic_pkg.sv | 29 ++
 rtl/traffic_light_ctrl_if.sv | 32 +++
 rtl/dwell_timer.sv | 35 +++
 rtl/traffic_light_ctrl.sv | 174 +++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller.
//   - state_e : FSM state codes (also driven out on state_dbg)
//   - light_t : {R,Y,G} one-hot lamp code and its three legal values
//   - DEF_*   : default dwell timer width and phase durations (clk cycles)
package traffic_pkg;

  typedef enum logic [2:0] {
    S_MG   = 3'd0,
    S_MY   = 3'd1,
    S_WALK = 3'd2,
    S_SG   = 3'd3,
    S_SY   = 3'd4,
    S_PROG = 3'd5
  } state_e;

  typedef logic [2:0] light_t;

  localparam light_t LT_RED = 3'b100;
  localparam light_t LT_YEL = 3'b010;
  localparam light_t LT_GRN = 3'b001;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_T_MAIN_G = 20;
  localparam int DEF_T_SIDE_G = 10;
  localparam int DEF_T_EXT    = 5;
  localparam int DEF_T_YEL    = 3;
  localparam int DEF_T_WALK   = 8;

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the input synchroniser / lamp drivers and the
// traffic light controller.
//   inputs to controller : sensor_sync, wr_sync, prog_sync
//   outputs              : main_light, side_light, walk_lamp,
//                          walk_pending, state_dbg
// There is no valid/ready handshake: every signal is a level that is
// meaningful on every clock cycle. Inputs are sampled on each posedge;
// outputs change only just after a posedge and depend on registers only.
interface traffic_light_ctrl_if;
  import traffic_pkg::*;

  logic       sensor_sync;
  logic       wr_sync;
  logic       prog_sync;
  light_t     main_light;
  light_t     side_light;
  logic       walk_lamp;
  logic       walk_pending;
  logic [2:0] state_dbg;

  // master: the environment driving the controller
  modport master (
    output sensor_sync, wr_sync, prog_sync,
    input  main_light, side_light, walk_lamp, walk_pending, state_dbg
  );

  // slave: the controller itself
  modport slave (
    input  sensor_sync, wr_sync, prog_sync,
    output main_light, side_light, walk_lamp, walk_pending, state_dbg
  );
endinterface

// File: rtl/dwell_timer.sv
// Phase dwell down-counter.
//   clk, reset : clock, synchronous active-high reset (count <= RST_VAL)
//   i_load     : load i_load_val this cycle (wins over decrement)
//   i_load_val : value to load (dwell - 1)
//   o_count    : current count
//   o_zero     : count is zero (last cycle of the phase)
// The counter holds at zero instead of wrapping.
module dwell_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Moore controller for one intersection: main-street lights, side-street
// lights and pedestrian walk lamp.
//   clk, reset : clock, synchronous active-high reset
//   bus        : traffic_light_ctrl_if.slave
//                in : sensor_sync, wr_sync, prog_sync (already synchronised)
//                out: main_light, side_light ({R,Y,G} one-hot), walk_lamp,
//                     walk_pending, state_dbg (current state code)
// Sequence MG -> MY -> [WALK] -> SG -> SY -> MG; prog_sync parks the
// intersection in all-red (PROG) from any state.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int T_MAIN_G = DEF_T_MAIN_G,
  parameter int T_SIDE_G = DEF_T_SIDE_G,
  parameter int T_EXT    = DEF_T_EXT,
  parameter int T_YEL    = DEF_T_YEL,
  parameter int T_WALK   = DEF_T_WALK
) (
  input  logic                 clk,
  input  logic                 reset,
  traffic_light_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] L_MAIN_G = CNT_W'(T_MAIN_G - 1);
  localparam logic [CNT_W-1:0] L_SIDE_G = CNT_W'(T_SIDE_G - 1);
  localparam logic [CNT_W-1:0] L_EXT    = CNT_W'(T_EXT - 1);
  localparam logic [CNT_W-1:0] L_YEL    = CNT_W'(T_YEL - 1);
  localparam logic [CNT_W-1:0] L_WALK   = CNT_W'(T_WALK - 1);

  state_e           r_state;
  logic             r_walk_pending;
  logic             r_ext_done;
  logic             r_sensor_seen;

  state_e           w_state_nxt;
  logic             w_wp_nxt;
  logic             w_ext_nxt;
  logic             w_seen_nxt;
  logic             w_to_walk;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_count;
  logic             w_zero;
  logic             w_last;
  logic             w_sg_seen;

  dwell_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (L_MAIN_G)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_count    (w_count),
    .o_zero     (w_zero)
  );

  assign w_last = w_zero & ~|w_count;

  // A car seen on the final side-green cycle still earns the extension.
  assign w_sg_seen = r_sensor_seen | bus.sensor_sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_MG;
      r_walk_pending <= 1'b0;
      r_ext_done     <= 1'b0;
      r_sensor_seen  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_walk_pending <= w_wp_nxt;
      r_ext_done     <= w_ext_nxt;
      r_sensor_seen  <= w_seen_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = L_MAIN_G;
    w_ext_nxt   = r_ext_done;
    w_seen_nxt  = r_sensor_seen;
    w_to_walk   = 1'b0;
    if (bus.prog_sync) begin
      w_state_nxt = S_PROG;
      w_load      = (r_state != S_PROG);
      w_load_val  = '0;
    end else begin
      case (r_state)
        S_MG: if (w_last) begin
          w_state_nxt = S_MY;
          w_load      = 1'b1;
          w_load_val  = L_YEL;
        end
        S_MY: if (w_last) begin
          w_load = 1'b1;
          if (r_walk_pending) begin
            w_state_nxt = S_WALK;
            w_load_val  = L_WALK;
            w_to_walk   = 1'b1;
          end else begin
            w_state_nxt = S_SG;
            w_load_val  = L_SIDE_G;
          end
        end
        S_WALK: if (w_last) begin
          w_state_nxt = S_SG;
          w_load      = 1'b1;
          w_load_val  = L_SIDE_G;
        end
        S_SG: begin
          w_seen_nxt = w_sg_seen;
          if (w_last) begin
            w_load = 1'b1;
            if (w_sg_seen && !r_ext_done) begin
              w_load_val = L_EXT;
              w_ext_nxt  = 1'b1;
            end else begin
              w_state_nxt = S_SY;
              w_load_val  = L_YEL;
            end
          end
        end
        S_SY: if (w_last) begin
          w_state_nxt = S_MG;
          w_load      = 1'b1;
          w_load_val  = L_MAIN_G;
          w_ext_nxt   = 1'b0;
          w_seen_nxt  = 1'b0;
        end
        // S_PROG released, or an illegal code: restart main green.
        default: begin
          w_state_nxt = S_MG;
          w_load      = 1'b1;
          w_load_val  = L_MAIN_G;
          w_ext_nxt   = 1'b0;
          w_seen_nxt  = 1'b0;
        end
      endcase
    end
  end

  // Walk latch: servicing (MY->WALK) beats a same-cycle request; requests
  // are ignored while walking or parked.
  always_comb begin
    w_wp_nxt = r_walk_pending;
    if (r_state == S_PROG || w_to_walk) begin
      w_wp_nxt = 1'b0;
    end else if (bus.wr_sync && r_state != S_WALK) begin
      w_wp_nxt = 1'b1;
    end
  end

  // Lamp decode from the state register only.
  always_comb begin
    bus.main_light = LT_RED;
    bus.side_light = LT_RED;
    bus.walk_lamp  = 1'b0;
    case (r_state)
      S_MG:    bus.main_light = LT_GRN;
      S_MY:    bus.main_light = LT_YEL;
      S_WALK:  bus.walk_lamp  = 1'b1;
      S_SG:    bus.side_light = LT_GRN;
      S_SY:    bus.side_light = LT_YEL;
      default: ;
    endcase
  end

  assign bus.walk_pending = r_walk_pending;
  assign bus.state_dbg    = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: two instances (default timing, and
// T_YEL=1/T_EXT=1) share the same stimulus. The reference model tracks
// each intersection as a phase plus cycles spent versus total dwell.
module tb_traffic_light_ctrl;

  localparam int P_MG = 0, P_MY = 1, P_WALK = 2, P_SG = 3, P_SY = 4, P_PROG = 5;
  localparam int TM = 20, TS = 10, TW = 8;
  localparam int FOREVER = 1 << 30;

  int t_yel [2] = '{3, 1};
  int t_ext [2] = '{5, 1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  traffic_light_ctrl_if if_a ();
  traffic_light_ctrl_if if_b ();

  traffic_light_ctrl u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  traffic_light_ctrl #(
    .T_YEL (1),
    .T_EXT (1)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b.slave)
  );

  // ---------------- reference model ----------------
  int m_ph [2];
  int m_el [2];  // cycles already spent in the phase
  int m_dw [2];  // total cycles the phase lasts
  bit m_ext [2];
  bit m_seen [2];
  bit m_wp [2];

  task automatic enter_phase(int k, int ph, int dw);
    m_ph[k] = ph;
    m_el[k] = 0;
    m_dw[k] = dw;
  endtask

  task automatic model_step(int k, bit rst, bit s, bit w, bit p);
    bit last, going_walk, wp_n, seen_n;
    if (rst) begin
      enter_phase(k, P_MG, TM);
      m_ext[k] = 0; m_seen[k] = 0; m_wp[k] = 0;
      return;
    end
    last       = (m_el[k] + 1 >= m_dw[k]);
    going_walk = !p && m_ph[k] == P_MY && last && m_wp[k];
    if (m_ph[k] == P_PROG || going_walk) wp_n = 0;
    else if (w && m_ph[k] != P_WALK)     wp_n = 1;
    else                                 wp_n = m_wp[k];
    if (p) begin
      if (m_ph[k] != P_PROG) enter_phase(k, P_PROG, FOREVER);
      else m_el[k]++;
    end else begin
      case (m_ph[k])
        P_MG:   if (last) enter_phase(k, P_MY, t_yel[k]); else m_el[k]++;
        P_MY:   if (last) enter_phase(k, m_wp[k] ? P_WALK : P_SG, m_wp[k] ? TW : TS);
                else m_el[k]++;
        P_WALK: if (last) enter_phase(k, P_SG, TS); else m_el[k]++;
        P_SG: begin
          seen_n = m_seen[k] | s;
          m_seen[k] = seen_n;
          if (last && seen_n && !m_ext[k]) begin
            m_dw[k] += t_ext[k];
            m_ext[k] = 1;
            m_el[k]++;
          end else if (last) enter_phase(k, P_SY, t_yel[k]);
          else m_el[k]++;
        end
        P_SY: if (last) begin
          enter_phase(k, P_MG, TM);
          m_ext[k] = 0; m_seen[k] = 0;
        end else m_el[k]++;
        default: begin
          enter_phase(k, P_MG, TM);
          m_ext[k] = 0; m_seen[k] = 0;
        end
      endcase
    end
    m_wp[k] = wp_n;
  endtask

  function automatic logic [10:0] exp_out(int k);
    logic [2:0] mn, sd;
    logic lamp;
    mn = 3'b100; sd = 3'b100; lamp = 1'b0;
    case (m_ph[k])
      P_MG:   mn = 3'b001;
      P_MY:   mn = 3'b010;
      P_WALK: lamp = 1'b1;
      P_SG:   sd = 3'b001;
      P_SY:   sd = 3'b010;
      default: ;
    endcase
    return {3'(m_ph[k]), mn, sd, lamp, m_wp[k]};
  endfunction

  // ---------------- scoreboard ----------------
  logic [21:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_cycle  = 0;

  task automatic check(string name, logic [10:0] got, logic [10:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got{st,main,side,lamp,wp}=%b exp=%b", name, n_cycle, got, exp);
    end
  endtask

  initial begin : monitor
    logic [21:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cycle++;
        check("dut_a", {if_a.state_dbg, if_a.main_light, if_a.side_light,
                        if_a.walk_lamp, if_a.walk_pending}, e[10:0]);
        check("dut_b", {if_b.state_dbg, if_b.main_light, if_b.side_light,
                        if_b.walk_lamp, if_b.walk_pending}, e[21:11]);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive(bit rst, bit s, bit w, bit p);
    @(negedge clk);
    reset            = rst;
    if_a.sensor_sync = s; if_b.sensor_sync = s;
    if_a.wr_sync     = w; if_b.wr_sync     = w;
    if_a.prog_sync   = p; if_b.prog_sync   = p;
    model_step(0, rst, s, w, p);
    model_step(1, rst, s, w, p);
    exp_q.push_back({exp_out(1), exp_out(0)});
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int prog_left;
    bit s, w, p, r;
    reset = 1'b1;
    if_a.sensor_sync = 0; if_a.wr_sync = 0; if_a.prog_sync = 0;
    if_b.sensor_sync = 0; if_b.wr_sync = 0; if_b.prog_sync = 0;

    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0);
    idle(80);                               // plain sequence
    drive(0, 0, 1, 0); idle(60);            // single walk pulse
    for (int i = 0; i < 40; i++) drive(0, 1, 0, 0);  // sensor held
    idle(60);
    for (int i = 0; i < 70; i++) drive(0, 0, 1, 0);  // walk request held
    idle(40);

    // prog for 4 cycles during side green with a pending walk
    for (int i = 0; i < 200 && m_ph[0] != P_SG; i++) drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1);
    idle(30);

    // reset together with prog in the middle of a walk phase
    drive(0, 0, 1, 0);
    for (int i = 0; i < 200 && m_ph[0] != P_WALK; i++) drive(0, 0, 0, 0);
    idle(3);
    drive(1, 0, 0, 1);
    idle(30);

    prog_left = 0;
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 5) == 0);
      w = ($urandom_range(0, 24) == 0);
      r = ($urandom_range(0, 499) == 0);
      if (prog_left > 0) begin
        p = 1; prog_left--;
      end else begin
        p = 0;
        if ($urandom_range(0, 149) == 0) prog_left = $urandom_range(1, 6);
      end
      drive(r, s, w, p);
    end

    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain got=%0d entries left exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
